ldpc_fetch_ctrl: RTL

//  LDPC-side reader of the de-interleaver main memory. Frame-ready (bidin_rdy) starts it.

---
 rtl/ldpc_fetch_if.sv | 33 +++
 rtl/ldpc_fetch_ctrl.sv | 133 +++++++++++++
 2 files changed

// File: rtl/ldpc_fetch_if.sv
// Signal bundle between the LDPC fetch controller, the de-interleaver main memory,
// the ping-pong codeword buffer and the decoder.
interface ldpc_fetch_if #(
    parameter int WID = 6
);
    logic           bidin_rdy;
    logic           bidin_full;
    logic           bidin_ena_out;
    logic [WID-1:0] bidin_dout;
    logic           ldpc_req;
    logic           ldpc_fin;
    logic           buf_wr_en;
    logic           buf_wr_bank;
    logic [13:0]    buf_wr_addr;
    logic [WID-1:0] buf_wr_data;
    logic           cw_rdy;
    logic           cw_bank;
    logic [3:0]     cw_idx;
    logic           dec_done;
    logic           frame_err;

    modport master (
        input  bidin_rdy, bidin_full, bidin_ena_out, bidin_dout, dec_done,
        output ldpc_req, ldpc_fin, buf_wr_en, buf_wr_bank, buf_wr_addr, buf_wr_data,
               cw_rdy, cw_bank, cw_idx, frame_err
    );

    modport slave (
        output bidin_rdy, bidin_full, bidin_ena_out, bidin_dout, dec_done,
        input  ldpc_req, ldpc_fin, buf_wr_en, buf_wr_bank, buf_wr_addr, buf_wr_data,
               cw_rdy, cw_bank, cw_idx, frame_err
    );
endinterface

// File: rtl/ldpc_fetch_ctrl.sv
// Reads one frame out of the de-interleaver memory codeword by codeword into a two-bank
// ping-pong buffer. Read latency is absorbed by counting returned symbols, not by timing.
module ldpc_fetch_ctrl #(
    parameter int WID    = 6,
    parameter int CW_LEN = 9216,
    parameter int CW_NUM = 15
) (
    input logic          clk,
    input logic          rst,
    ldpc_fetch_if.master bus
);
    typedef enum logic [2:0] {IDLE, REQ, DRAIN, WAIT_BUF, FIN} state_t;

    localparam logic [13:0] CW_SIZE  = 14'(CW_LEN);
    localparam logic [13:0] CW_LAST  = 14'(CW_LEN - 1);
    localparam logic [3:0]  FRM_LAST = 4'(CW_NUM - 1);

    state_t         state, state_nxt;
    logic [13:0]    req_cnt, rx_cnt;
    logic [3:0]     cw_cnt;
    logic [1:0]     bank_full, full_rel, full_nxt;
    logic           wr_bank, rd_bank;
    logic           rel_ok, rx_full, rx_take, cw_done;
    logic           wr_en_q, wr_bank_q, err_q;
    logic [13:0]    wr_addr_q;
    logic [WID-1:0] wr_data_q;

    assign rx_full = (rx_cnt == CW_SIZE);
    assign rx_take = bus.bidin_ena_out && (state != IDLE) && !rx_full;

    // Release is applied before fill: a bank freed in the completion cycle already reads free.
    always_comb begin
        rel_ok   = bus.dec_done && bank_full[rd_bank];
        full_rel = bank_full;
        if (rel_ok) full_rel[rd_bank] = 1'b0;
    end

    always_comb begin
        full_nxt = full_rel;
        if (cw_done) full_nxt[wr_bank] = 1'b1;
    end

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_nxt    = state;
        bus.ldpc_req = 1'b0;
        bus.ldpc_fin = 1'b0;
        cw_done      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.bidin_rdy) state_nxt = full_rel[wr_bank] ? WAIT_BUF : REQ;
            end
            REQ: begin
                bus.ldpc_req = 1'b1;
                if (req_cnt == CW_LAST) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (rx_full) begin
                    cw_done = 1'b1;
                    if (cw_cnt == FRM_LAST)    state_nxt = FIN;
                    else if (full_rel[~wr_bank]) state_nxt = WAIT_BUF;
                    else                       state_nxt = REQ;
                end
            end
            WAIT_BUF: begin
                if (!bank_full[wr_bank]) state_nxt = REQ;
            end
            FIN: begin
                bus.ldpc_fin = 1'b1;
                state_nxt    = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_cnt   <= '0;
            rx_cnt    <= '0;
            cw_cnt    <= '0;
            bank_full <= '0;
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_bank_q <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            err_q     <= 1'b0;
        end else begin
            if (state == REQ) req_cnt <= (req_cnt == CW_LAST) ? '0 : req_cnt + 14'd1;

            wr_en_q <= rx_take;
            if (rx_take) begin
                wr_addr_q <= rx_cnt;
                wr_bank_q <= wr_bank;
                wr_data_q <= bus.bidin_dout;
                rx_cnt    <= rx_cnt + 14'd1;
            end

            if (cw_done) begin
                rx_cnt  <= '0;
                wr_bank <= ~wr_bank;
                cw_cnt  <= (cw_cnt == FRM_LAST) ? '0 : cw_cnt + 4'd1;
            end else if (state == IDLE) begin
                cw_cnt <= '0;
            end

            bank_full <= full_nxt;
            if (rel_ok) rd_bank <= ~rd_bank;

            // Stray frame starts, unexpected data and releases of an empty buffer are all sticky.
            if ((bus.bidin_rdy && state != IDLE) ||
                (bus.bidin_ena_out && !rx_take) ||
                (bus.dec_done && !rel_ok))
                err_q <= 1'b1;
        end
    end

    assign bus.buf_wr_en   = wr_en_q;
    assign bus.buf_wr_bank = wr_bank_q;
    assign bus.buf_wr_addr = wr_addr_q;
    assign bus.buf_wr_data = wr_data_q;
    assign bus.cw_rdy      = cw_done;
    assign bus.cw_bank     = cw_done & wr_bank;
    assign bus.cw_idx      = cw_done ? cw_cnt : 4'd0;
    assign bus.frame_err   = err_q;
endmodule
